// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters, with a one-entry registered response buffer per port.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [2:0]       r0_op,
    input  logic             r0_ctrl,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_lt,
    input  logic             r0_ltu,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [2:0]       r1_op,
    input  logic             r1_ctrl,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_lt,
    input  logic             r1_ltu,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_neg,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_neg,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_operation,
    output logic             alu_control,
    output logic             alu_lt,
    output logic             alu_ltu,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_neg
);

    typedef struct packed {
        logic [2:0]       op;
        logic             ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             lt;
        logic             ltu;
    } req_t;

    req_t req0;
    req_t req1;
    req_t sel;

    logic prio;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;

    assign req0 = {r0_op, r0_ctrl, r0_a, r0_b, r0_lt, r0_ltu};
    assign req1 = {r1_op, r1_ctrl, r1_a, r1_b, r1_lt, r1_ltu};

    // A slot being drained this cycle can accept a new result at the same edge.
    assign elig0 = r0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = r1_valid && (!rsp1_valid || rsp1_ready);

    assign gnt0 = elig0 && (!elig1 || !prio);
    assign gnt1 = elig1 && (!elig0 || prio);

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    always_comb begin
        sel = '0;
        unique case (1'b1)
            gnt0:    sel = req0;
            gnt1:    sel = req1;
            default: sel = '0;
        endcase
    end

    assign alu_a         = sel.a;
    assign alu_b         = sel.b;
    assign alu_operation = sel.op;
    assign alu_control   = sel.ctrl;
    assign alu_lt        = sel.lt;
    assign alu_ltu       = sel.ltu;

    // The granted port hands priority to the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_neg    <= 1'b0;
        end else if (gnt0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
            rsp0_neg    <= alu_neg;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_neg    <= 1'b0;
        end else if (gnt1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
            rsp1_neg    <= alu_neg;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed plus random checks of alu_share_arb against
// a transaction-level model of arbitration and response buffering.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_ctrl, r0_lt, r0_ltu;
    logic [2:0]  r0_op;
    logic [31:0] r0_a, r0_b;
    logic        r1_valid, r1_ready, r1_ctrl, r1_lt, r1_ltu;
    logic [2:0]  r1_op;
    logic [31:0] r1_a, r1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_neg;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_neg;
    logic [31:0] rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_operation;
    logic        alu_control, alu_lt, alu_ltu, alu_zero, alu_neg;

    int passed = 0;
    int total  = 0;

    // Model state
    logic        mprio;
    logic        mvld [2];
    logic [31:0] mres [2];
    logic        mzero[2];
    logic        mneg [2];
    logic        st0, st1;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r0_lt(r0_lt), .r0_ltu(r0_ltu),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .r1_lt(r1_lt), .r1_ltu(r1_ltu),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_neg(rsp0_neg),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_neg(rsp1_neg),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .alu_control(alu_control), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg)
    );

    function automatic logic [31:0] alu_fn(logic [2:0] op, logic c,
                                           logic [31:0] a, logic [31:0] b,
                                           logic lt, logic ltu);
        case (op)
            3'd0:    return c ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, lt};
            3'd3:    return {31'b0, ltu};
            3'd4:    return a ^ b;
            3'd5:    return c ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Stand-in for the shared ALU
    always_comb begin
        alu_result = alu_fn(alu_operation, alu_control, alu_a, alu_b,
                            alu_lt, alu_ltu);
        alu_zero   = (alu_result == 32'd0);
        alu_neg    = alu_result[31];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mprio = 1'b0;
        st0   = 1'b0;
        st1   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mvld[i]  = 1'b0;
            mres[i]  = 32'd0;
            mzero[i] = 1'b0;
            mneg[i]  = 1'b0;
        end
    endtask

    task automatic chk_rsp();
        chk("rsp0_valid",  rsp0_valid,  mvld[0]);
        chk("rsp0_result", rsp0_result, mres[0]);
        chk("rsp0_flags",  {rsp0_zero, rsp0_neg}, {mzero[0], mneg[0]});
        chk("rsp1_valid",  rsp1_valid,  mvld[1]);
        chk("rsp1_result", rsp1_result, mres[1]);
        chk("rsp1_flags",  {rsp1_zero, rsp1_neg}, {mzero[1], mneg[1]});
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic        e0, e1, g0, g1;
        logic [31:0] ea, eb, res;
        logic [5:0]  ectl;
        e0 = r0_valid && (!mvld[0] || rsp0_ready);
        e1 = r1_valid && (!mvld[1] || rsp1_ready);
        g0 = e0 && (!e1 || !mprio);
        g1 = e1 && (!e0 || mprio);
        ea = 0; eb = 0; ectl = 0;
        if (g0) begin
            ea = r0_a; eb = r0_b;
            ectl = {r0_op, r0_ctrl, r0_lt, r0_ltu};
        end else if (g1) begin
            ea = r1_a; eb = r1_b;
            ectl = {r1_op, r1_ctrl, r1_lt, r1_ltu};
        end
        #1;
        chk("r0_ready", r0_ready, g0);
        chk("r1_ready", r1_ready, g1);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_ctl", {alu_operation, alu_control, alu_lt, alu_ltu}, ectl);
        @(posedge clk);
        if (g0) begin
            res = alu_fn(r0_op, r0_ctrl, r0_a, r0_b, r0_lt, r0_ltu);
            mvld[0] = 1; mres[0] = res;
            mzero[0] = (res == 0); mneg[0] = res[31];
        end else if (rsp0_ready) mvld[0] = 0;
        if (g1) begin
            res = alu_fn(r1_op, r1_ctrl, r1_a, r1_b, r1_lt, r1_ltu);
            mvld[1] = 1; mres[1] = res;
            mzero[1] = (res == 0); mneg[1] = res[31];
        end else if (rsp1_ready) mvld[1] = 0;
        if (g0) mprio = 1;
        else if (g1) mprio = 0;
        st0 = r0_valid && !g0;
        st1 = r1_valid && !g1;
        @(negedge clk);
        chk_rsp();
    endtask

    task automatic set_r0(logic v, logic [2:0] op, logic c,
                          logic [31:0] a, logic [31:0] b);
        r0_valid = v; r0_op = op; r0_ctrl = c; r0_a = a; r0_b = b;
        r0_lt = 0; r0_ltu = 0;
    endtask

    task automatic set_r1(logic v, logic [2:0] op, logic c,
                          logic [31:0] a, logic [31:0] b);
        r1_valid = v; r1_op = op; r1_ctrl = c; r1_a = a; r1_b = b;
        r1_lt = 0; r1_ltu = 0;
    endtask

    task automatic rand_req(int n);
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if (n == 0) begin
            set_r0($urandom_range(0, 9) < 6, 3'($urandom), 1'($urandom), a, b);
            r0_lt = 1'($urandom); r0_ltu = 1'($urandom);
        end else begin
            set_r1($urandom_range(0, 9) < 6, 3'($urandom), 1'($urandom), a, b);
            r1_lt = 1'($urandom); r1_ltu = 1'($urandom);
        end
    endtask

    initial begin
        rst_n = 0;
        set_r0(0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0);
        rsp0_ready = 0;
        rsp1_ready = 0;
        model_reset();
        #3;
        chk_rsp();
        chk("rst_r0_ready", r0_ready, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Lone add on port 0
        set_r0(1, 3'd0, 0, 32'd5, 32'd7);
        rsp0_ready = 1;
        cycle();
        chk("add_result", rsp0_result, 32'd12);
        set_r0(0, 0, 0, 0, 0);
        cycle();

        // Sub 3-5, then hold the response for three cycles
        set_r0(1, 3'd0, 1, 32'd3, 32'd5);
        cycle();
        rsp0_ready = 0;
        set_r0(1, 3'd0, 0, 32'd1, 32'd1);
        repeat (3) begin
            cycle();
            chk("sub_held", rsp0_result, 32'hFFFF_FFFE);
            chk("sub_neg", rsp0_neg, 1'b1);
        end
        rsp0_ready = 1;
        cycle();
        chk("refill", rsp0_result, 32'd2);

        // Port 0 blocked, port 1 streams
        rsp0_ready = 0;
        rsp1_ready = 1;
        set_r1(1, 3'd4, 0, 32'hF0F0_0000, 32'h0F0F_1234);
        repeat (4) cycle();

        // Contention with both drained every cycle
        rsp0_ready = 1;
        set_r0(1, 3'd6, 0, 32'h10, 32'h01);
        repeat (6) cycle();

        // Idle
        set_r0(0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Reset mid-cycle with a pending response on port 1
        rsp1_ready = 0;
        set_r1(1, 3'd7, 0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        cycle();
        set_r1(0, 0, 0, 0, 0);
        cycle();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("mid_rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("mid_rst_rsp1_result", rsp1_result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        rsp1_ready = 1;
        set_r0(1, 3'd1, 0, 32'd1, 32'd4);
        set_r1(1, 3'd0, 0, 32'd9, 32'd9);
        cycle();
        chk("prio_after_rst", rsp0_valid, 1'b1);

        // Random traffic obeying the hold rule
        repeat (400) begin
            if (!st0) rand_req(0);
            if (!st1) rand_req(1);
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
